inv_key_schedule: RTL
=====================

# inv_key_schedule

Sequential AES-128 inverse key schedule for the decryption datapath. From the round-10 key (last round key) it regenerates round keys 10, 9, …, 0 in descending order, one per output handshake, by running the key-expansion recurrence backwards with the G operation. It sits between the key register and the inverse-round datapath, so decryption needs no 11-entry round-key store.

## Interface
- No parameters. Fixed at AES-128: 10 rounds, 128-bit keys.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  accepted only in IDLE. Loads `key_in`.
- `key_in`  in  128  round-10 key; `[127:96]` is word 0. Cipher key when `INV_KEYSCHED_EXPAND_EN` is defined.
- `key_ready`  in  1  downstream accepts `round_key` this cycle.
- `key_valid`  out  1  `round_key` and `round_num` are valid.
- `round_key`  out  128  current round key, word 0 in MSBs.
- `round_num`  out  4  round index of `round_key`, 10 down to 0.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE, EXPAND (only with the macro), EMIT.
- IDLE:
  - With `start`=1, register `key_in` and set `round_num`=10.
  - Next state is EMIT, or EXPAND with the macro.
  - `start` in any other state is ignored.
- EMIT:
  - `key_valid`=1.
  - On `key_valid & key_ready` with `round_num`>0:
    - Let k0..k3 be the current key words and r = `round_num`.
    - Next words: p1 = k1^k0, p2 = k2^k1, p3 = k3^k2, p0 = k0 ^ G(p3, rcon[r]).
    - `round_num` decrements by 1.
  - On handshake with `round_num`=0: go to IDLE and pulse `done`.
  - Without handshake: `round_key` and `round_num` hold stable. This is AXI-style; `key_valid` does not drop once raised until accepted.
- G(w, rc) = SubWord(RotWord(w)) ^ rc. RotWord rotates left by one byte. rc = {rcon_byte, 24'h0}.
- rcon bytes, index 1..10: 01 02 04 08 10 20 40 80 1b 36. The reverse step from round r uses rcon[r].
- All XORs are bitwise, 32 bits wide. There is no arithmetic carry.
- Reset in any state:
  - Returns to IDLE.
  - `key_valid`=0, `busy`=0, `done`=0, `round_num`=0, `round_key`=0.
  - Any in-progress sequence is aborted and not resumed.

## Timing
- `start` in cycle T → `key_valid`=1 with round 10 at T+1 (no macro).
- Each accepted handshake at cycle T presents the next key at T+1. With `key_ready` held high, one key is produced per cycle.
- A full sequence is 11 cycles plus 1 cycle to load. `done` is asserted in the cycle after the round-0 handshake, and the state is IDLE in that same cycle.
- `start` is accepted in the same cycle that `done` is high. Back-to-back sequences are allowed.
- The G path is combinational within one cycle: 4 S-box lookups plus the XOR tree.

## Configuration
- Macro: `INV_KEYSCHED_EXPAND_EN`.
- Defined:
  - `key_in` is the cipher (round-0) key.
  - The EXPAND state runs the forward recurrence for 10 cycles: w0' = w0^G(w3, rcon[i]), then a chained XOR for w1'..w3'.
  - EMIT is entered with round 10. `start`→first `key_valid` latency is 11 cycles.
  - `busy`=1 and `key_valid`=0 during EXPAND.
  - Reset during EXPAND returns to IDLE.
- Undefined:
  - No EXPAND state and no forward logic.
  - `key_in` must be the round-10 key.

## Structure
- Shared package `aes_pkg`:
  - `NUM_ROUNDS`=10.
  - `RCON` lookup, a function indexed by round.
  - `key_state_t` enum {IDLE, EXPAND, EMIT}.
  - `aes_word_t` (32 bit).
- One sub-module: `inv_key_step`, combinational. Inputs: 128-bit key and 4-bit round. Output: previous round key. It instantiates the existing G operation. When the macro is enabled, the forward step reuses the same G instance through a mux on the G input.

## Test plan
- FIPS-197 A.1, no macro:
  - Stimulus: `key_in`=d014f9a8c9ee2589e13f0cc8b6630ca6, `start` for 1 cycle, `key_ready`=1.
  - Round 10 appears at T+1.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - `done` pulses at T+12.
- Backpressure: `key_ready` low for 3 cycles while on round 7.
  - `round_key` and `round_num` hold stable and `key_valid` stays 1.
  - Round 6 follows one cycle after `key_ready` rises.
- Reset mid-sequence: assert `rst` with `round_num`=5.
  - Next cycle: `key_valid`=0, `busy`=0, `round_key`=0.
  - A new `start` then produces round 10 correctly.
- Ignored start and back-to-back sequences:
  - `start` pulsed during EMIT has no effect.
  - `start` asserted in the cycle `done` is high begins a new sequence, with round 10 valid on the next cycle.
- Macro enabled: `key_in`=2b7e151628aed2a6abf7158809cf4f3c.
  - `busy` is high for 10 cycles with `key_valid`=0.
  - Then round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, followed by the same descending sequence as the first test.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - Shared AES-128 types, round constants and S-box lookup.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} key_state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_g_word.sv
// rtl/aes_g_word.sv - Key-schedule G operation: SubWord(RotWord(w)) ^ {rcon, 24'h0}.
module aes_g_word
  import aes_pkg::*;
(
  input  logic [31:0] i_w,
  input  logic [7:0]  i_rcon,
  output logic [31:0] o_g
);

  assign o_g = {sbox(i_w[23:16]) ^ i_rcon, sbox(i_w[15:8]), sbox(i_w[7:0]), sbox(i_w[31:24])};

endmodule

// File: rtl/inv_key_step.sv
// rtl/inv_key_step.sv - One combinational key-schedule step, reverse (forward too with INV_KEYSCHED_EXPAND_EN).
module inv_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [3:0]   i_round,
`ifdef INV_KEYSCHED_EXPAND_EN
  input  logic         i_fwd,
`endif
  output logic [127:0] o_key
);

  aes_word_t w_k0, w_k1, w_k2, w_k3;
  aes_word_t w_p1, w_p2, w_p3;
  aes_word_t w_g_in, w_g_out, w_n0;

  assign w_k0 = i_key[127:96];
  assign w_k1 = i_key[95:64];
  assign w_k2 = i_key[63:32];
  assign w_k3 = i_key[31:0];

  assign w_p1 = w_k1 ^ w_k0;
  assign w_p2 = w_k2 ^ w_k1;
  assign w_p3 = w_k3 ^ w_k2;

  // Word 0 is k0 ^ G(..) in both directions; only the G input differs.
  assign w_n0 = w_k0 ^ w_g_out;

  aes_g_word u_g (
    .i_w    (w_g_in),
    .i_rcon (rcon(i_round)),
    .o_g    (w_g_out)
  );

`ifdef INV_KEYSCHED_EXPAND_EN
  aes_word_t w_n1, w_n2, w_n3;

  assign w_g_in = i_fwd ? w_k3 : w_p3;
  assign w_n1   = w_k1 ^ w_n0;
  assign w_n2   = w_k2 ^ w_n1;
  assign w_n3   = w_k3 ^ w_n2;
  assign o_key  = i_fwd ? {w_n0, w_n1, w_n2, w_n3} : {w_n0, w_p1, w_p2, w_p3};
`else
  assign w_g_in = w_p3;
  assign o_key  = {w_n0, w_p1, w_p2, w_p3};
`endif

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - AES-128 inverse key schedule emitting round keys 10..0; optional INV_KEYSCHED_EXPAND_EN.
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         busy,
  output logic         done
);

  key_state_t   r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_valid;
  logic         r_busy;
  logic         r_done;
  logic [127:0] w_step_key;
  logic         w_hs;

  assign w_hs      = r_valid & key_ready;
  assign key_valid = r_valid;
  assign round_key = r_key;
  assign round_num = r_round;
  assign busy      = r_busy;
  assign done      = r_done;

  inv_key_step u_step (
    .i_key   (r_key),
    .i_round (r_round),
`ifdef INV_KEYSCHED_EXPAND_EN
    .i_fwd   (r_state == EXPAND),
`endif
    .o_key   (w_step_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_key  <= key_in;
            r_busy <= 1'b1;
`ifdef INV_KEYSCHED_EXPAND_EN
            r_round <= 4'd1;
            r_state <= EXPAND;
`else
            r_round <= 4'(NUM_ROUNDS);
            r_valid <= 1'b1;
            r_state <= EMIT;
`endif
          end
        end
`ifdef INV_KEYSCHED_EXPAND_EN
        // r_round is the round being produced, so the last step leaves it at 10.
        EXPAND: begin
          r_key <= w_step_key;
          if (r_round == 4'(NUM_ROUNDS)) begin
            r_valid <= 1'b1;
            r_state <= EMIT;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
`endif
        EMIT: begin
          if (w_hs) begin
            if (r_round == 4'd0) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_key   <= w_step_key;
              r_round <= r_round - 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
